// File: rtl/eeprom_i2c_pkg.sv
// rtl/eeprom_i2c_pkg.sv - shared types and constants for the 2-wire EEPROM responder
package eeprom_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  localparam logic [3:0] DEV_CODE_DEF = 4'b1010;
  localparam logic       ACK  = 1'b0;
  localparam logic       NACK = 1'b1;

  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = BIT_CNT_W'(8);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT      = BIT_CNT_W'(7);

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers, SCL edge strobes and START/STOP detection
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0],[1] synchronize, [2] is the history flop; reset to idle-bus high
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_level = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start     = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop      = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/eeprom_i2c_slave.sv
// rtl/eeprom_i2c_slave.sv - 2K x 8 serial EEPROM responder; EEPROM_WRITE_BUSY_EN adds a post-STOP write cycle
module eeprom_i2c_slave
  import eeprom_i2c_pkg::*;
#(
  parameter int         ADDR_W    = 11,
  parameter int         MEM_DEPTH = 2048,
  parameter int         PAGE_SIZE = 16,
  parameter logic [3:0] DEV_CODE  = DEV_CODE_DEF
`ifdef EEPROM_WRITE_BUSY_EN
  ,
  parameter int         TWR_CYCLES = 1000
`endif
) (
  input  logic CLK,
  input  logic RESET,
  input  logic SCL,
  inout  wire  SDA,
  output logic BUSY,
  output logic WR_PULSE
);

  localparam int PG_W = $clog2(PAGE_SIZE);

  logic [7:0] mem [MEM_DEPTH];

  state_t               state, state_n;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           sh;
  logic [ADDR_W-1:0]    ptr;
  logic                 rw;
  logic                 sda_low;
  logic                 commit;
  logic                 twr_busy;

  logic sda_level, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk      (CLK),
    .rst      (RESET),
    .scl      (SCL),
    .sda      (SDA),
    .sda_level(sda_level),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  // RESET gates the driver directly so the bus is freed without waiting for CLK
  assign SDA = (sda_low && !RESET) ? 1'b0 : 1'bz;

  assign commit = (state == ST_WDATA) && scl_rise && (bit_cnt == LAST_BIT);

`ifdef EEPROM_WRITE_BUSY_EN
  localparam int TWR_W = $clog2(TWR_CYCLES + 1);
  logic [TWR_W-1:0] twr_cnt;
  logic             wrote;

  assign twr_busy = (twr_cnt != '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      twr_cnt <= '0;
      wrote   <= 1'b0;
    end else if (stop && wrote) begin
      twr_cnt <= TWR_W'(TWR_CYCLES);
      wrote   <= 1'b0;
    end else begin
      if (twr_busy) twr_cnt <= twr_cnt - TWR_W'(1);
      if (commit)   wrote   <= 1'b1;
    end
  end
`else
  assign twr_busy = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = ST_CTRL;
    end else if (stop) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_CTRL:
          if (scl_fall && bit_cnt == BITS_PER_BYTE)
            state_n = (sh[7:4] == DEV_CODE && !twr_busy) ? ST_CTRL_ACK : ST_IGNORE;
        ST_CTRL_ACK:  if (scl_fall) state_n = rw ? ST_RDATA : ST_ADDR;
        ST_ADDR:      if (scl_fall && bit_cnt == BITS_PER_BYTE) state_n = ST_ADDR_ACK;
        ST_ADDR_ACK:  if (scl_fall) state_n = ST_WDATA;
        ST_WDATA:     if (scl_fall && bit_cnt == BITS_PER_BYTE) state_n = ST_WDATA_ACK;
        ST_WDATA_ACK: if (scl_fall) state_n = ST_WDATA;
        ST_RDATA:     if (scl_fall && bit_cnt == LAST_BIT) state_n = ST_RDATA_ACK;
        ST_RDATA_ACK:
          if (scl_rise && sda_level == NACK) state_n = ST_IGNORE;
          else if (scl_fall)                 state_n = ST_RDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    sda_low = 1'b0;
    case (state)
      ST_CTRL_ACK, ST_ADDR_ACK, ST_WDATA_ACK: sda_low = 1'b1;
      ST_RDATA:                               sda_low = ~sh[7];
      default: ;
    endcase
    BUSY = (state != ST_IDLE) || twr_busy;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt  <= '0;
      sh       <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      WR_PULSE <= 1'b0;
    end else begin
      WR_PULSE <= commit;
      if (start || stop) begin
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_CTRL, ST_ADDR, ST_WDATA: begin
            if (scl_rise) begin
              sh      <= {sh[6:0], sda_level};
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            if (commit)
              ptr <= {ptr[ADDR_W-1:PG_W], ptr[PG_W-1:0] + PG_W'(1)};
            if (scl_fall && bit_cnt == BITS_PER_BYTE) begin
              bit_cnt <= '0;
              if (state == ST_CTRL) begin
                rw <= sh[0];
                if (sh[7:4] == DEV_CODE) ptr[ADDR_W-1:8] <= sh[ADDR_W-8:1];
              end else if (state == ST_ADDR) begin
                ptr[7:0] <= sh;
              end
            end
          end
          ST_CTRL_ACK:
            if (scl_fall && rw) begin
              sh      <= mem[ptr];
              bit_cnt <= '0;
            end
          ST_RDATA:
            if (scl_fall) begin
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                ptr     <= ptr + ADDR_W'(1);
              end else begin
                sh      <= {sh[6:0], 1'b1};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          ST_RDATA_ACK:
            if (scl_fall) sh <= mem[ptr];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (commit) mem[ptr] <= {sh[6:0], sda_level};
  end

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// tb/tb_eeprom_i2c_slave.sv - bus-master bench for eeprom_i2c_slave with a read-data scoreboard
module tb_eeprom_i2c_slave;

  localparam time Q = 100;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic SCL = 1'b1;
  logic m_low = 1'b0;
  wire  SDA;
  logic BUSY;
  logic WR_PULSE;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  logic [7:0] exp_q[$];

  assign SDA = m_low ? 1'b0 : 1'bz;
  pullup (SDA);

  eeprom_i2c_slave dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SCL     (SCL),
    .SDA     (SDA),
    .BUSY    (BUSY),
    .WR_PULSE(WR_PULSE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (WR_PULSE === 1'b1) wr_cnt++;

  task automatic bit_xfer(input logic b, output logic rd);
    m_low = ~b;
    #Q SCL = 1'b1;
    #Q rd = SDA;
    #Q SCL = 1'b0;
    #Q;
  endtask

  task automatic i2c_start;
    m_low = 1'b0;
    #Q SCL = 1'b1;
    #Q m_low = 1'b1;
    #Q SCL = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    m_low = 1'b1;
    #Q SCL = 1'b1;
    #Q m_low = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_n);
    logic d;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
    bit_xfer(1'b1, ack_n);
  endtask

  task automatic recv_byte(input logic last, output logic [7:0] b, output logic ack_slot);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, d);
      b[i] = d;
    end
    bit_xfer(last, ack_slot);
  endtask

  task automatic wr_txn(input logic [7:0] ctrl, input logic [7:0] addr,
                        input logic [23:0] data, input int n, output logic [4:0] nk);
    logic a;
    nk = '0;
    i2c_start;
    send_byte(ctrl, a); nk[0] = a;
    send_byte(addr, a); nk[1] = a;
    for (int i = 0; i < n; i++) begin
      send_byte(data[23-8*i -: 8], a);
      nk[2+i] = a;
    end
    i2c_stop;
  endtask

  task automatic test_reset;
    #2;
    tests++; if (SDA !== 1'b1) begin fails++; $display("FAIL reset_sda got=%b want=1", SDA); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    tests++; if (WR_PULSE !== 1'b0) begin fails++; $display("FAIL reset_wr_pulse got=%b want=0", WR_PULSE); end
    #100 RESET = 1'b0;
    #100;
  endtask

  task automatic test_byte_write;
    logic [4:0] nk;
    int w0;
    w0 = wr_cnt;
    wr_txn(8'hA2, 8'h34, {8'h5A, 16'h0}, 1, nk);
    tests++; if (nk[2:0] !== 3'b000) begin fails++; $display("FAIL bw_acks got=%b want=000", nk[2:0]); end
    tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL bw_wr_pulse got=%0d want=1", wr_cnt - w0); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL bw_busy_after_stop got=%b want=0", BUSY); end
  endtask

  task automatic test_random_read;
    logic a0, a1, a2, ns;
    logic [7:0] b, e;
    i2c_start;
    send_byte(8'hA2, a0);
    send_byte(8'h34, a1);
    i2c_start;
    send_byte(8'hA3, a2);
    tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL rr_busy got=%b want=1", BUSY); end
    exp_q.push_back(8'h5A);
    recv_byte(1'b1, b, ns);
    i2c_stop;
    tests++; if ({a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL rr_acks got=%b want=000", {a0, a1, a2}); end
    e = exp_q.pop_front();
    tests++; if (b !== e) begin fails++; $display("FAIL rr_data got=%h want=%h", b, e); end
    tests++; if (ns !== 1'b1) begin fails++; $display("FAIL rr_release_after_bit8 got=%b want=1", ns); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL rr_idle got=%b want=0", BUSY); end
  endtask

  task automatic test_page_wrap;
    logic [4:0] nk, pre;
    logic a0, a1, a2, s;
    logic [7:0] b, e;
    int w0;
    wr_txn(8'hA0, 8'h10, {8'h77, 16'h0}, 1, pre);
    wr_txn(8'hAE, 8'hFF, {8'hC1, 16'h0}, 1, nk); pre = pre | nk;
    wr_txn(8'hA0, 8'h01, {8'hC2, 16'h0}, 1, nk); pre = pre | nk;
    w0 = wr_cnt;
    wr_txn(8'hA0, 8'h0E, {8'h11, 8'h22, 8'h33}, 3, nk);
    tests++; if ((nk | pre) !== 5'b00000) begin fails++; $display("FAIL pw_acks got=%b want=00000", nk | pre); end
    tests++; if (wr_cnt - w0 != 3) begin fails++; $display("FAIL pw_wr_pulses got=%0d want=3", wr_cnt - w0); end
    i2c_start;
    send_byte(8'hA0, a0);
    send_byte(8'h0E, a1);
    i2c_start;
    send_byte(8'hA1, a2);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h77);
    for (int i = 0; i < 3; i++) begin
      recv_byte(i == 2, b, s);
      e = exp_q.pop_front();
      tests++; if (b !== e) begin fails++; $display("FAIL pw_readback[%0d] got=%h want=%h", i, b, e); end
    end
    i2c_stop;
  endtask

  task automatic test_seq_read_wrap;
    logic a0, a1, a2, s;
    logic [7:0] b, e;
    i2c_start;
    send_byte(8'hAE, a0);
    send_byte(8'hFF, a1);
    i2c_start;
    send_byte(8'hAF, a2);
    tests++; if ({a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL sr_acks got=%b want=000", {a0, a1, a2}); end
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'hC2);
    for (int i = 0; i < 3; i++) begin
      recv_byte(i == 2, b, s);
      e = exp_q.pop_front();
      tests++; if (b !== e) begin fails++; $display("FAIL sr_data[%0d] got=%h want=%h", i, b, e); end
    end
    i2c_stop;
  endtask

  task automatic test_foreign;
    logic a0, a1, a2;
    logic [4:0] nk;
    int w0;
    i2c_start;
    send_byte(8'h90, a0);
    send_byte(8'h55, a1);
    send_byte(8'hAA, a2);
    i2c_stop;
    tests++; if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL fg_no_ack got=%b want=111", {a0, a1, a2}); end
    w0 = wr_cnt;
    wr_txn(8'hA0, 8'h20, {8'h44, 16'h0}, 1, nk);
    tests++; if (nk[2:0] !== 3'b000) begin fails++; $display("FAIL fg_next_acks got=%b want=000", nk[2:0]); end
    tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL fg_next_wr got=%0d want=1", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid_read;
    logic a0, a1, a2, d, s;
    logic [6:0] hi;
    logic [7:0] b, e;
    i2c_start;
    send_byte(8'hA2, a0);
    send_byte(8'h34, a1);
    i2c_start;
    send_byte(8'hA3, a2);
    for (int i = 6; i >= 0; i--) begin
      bit_xfer(1'b1, d);
      hi[i] = d;
    end
    tests++; if (hi !== 7'b0101101) begin fails++; $display("FAIL rm_upper_bits got=%b want=0101101", hi); end
    tests++; if (SDA !== 1'b0) begin fails++; $display("FAIL rm_driving_bit0 got=%b want=0", SDA); end
    RESET = 1'b1;
    #1;
    tests++; if (SDA !== 1'b1) begin fails++; $display("FAIL rm_sda_released got=%b want=1", SDA); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL rm_busy got=%b want=0", BUSY); end
    #99 RESET = 1'b0;
    #Q;
    i2c_stop;
    i2c_start;
    send_byte(8'hA1, a0);
    exp_q.push_back(8'h33);
    recv_byte(1'b1, b, s);
    i2c_stop;
    tests++; if (a0 !== 1'b0) begin fails++; $display("FAIL rm_ctrl_ack got=%b want=0", a0); end
    e = exp_q.pop_front();
    tests++; if (b !== e) begin fails++; $display("FAIL rm_ptr0_data got=%h want=%h", b, e); end
  endtask

  initial begin
    test_reset;
    test_byte_write;
    test_random_read;
    test_page_wrap;
    test_seq_read_wrap;
    test_foreign;
    test_reset_mid_read;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
